vcxo_discipline_ctrl: RTL

VCXO_DISCIPLINE_CTRL -- requirements
Module: vcxo_discipline_ctrl

---
 rtl/vcxo_discipline_ctrl_pkg.sv | 25 ++
 rtl/vcxo_discipline_ctrl_sd_pwm.sv | 38 +++
 rtl/vcxo_discipline_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/vcxo_discipline_ctrl_pkg.sv
// Shared definitions for the VCXO disciplining controller: the measurement
// FSM state type and the default loop thresholds and step sizes.
package vcxo_discipline_ctrl_pkg;

  typedef enum logic [0:0] {
    WAIT_START = 1'b0,
    MEASURE    = 1'b1
  } measState_e;

  localparam int DEF_NOMINAL_COUNT = 12288000;
  localparam int DEF_GATE_EDGES    = 1228800;
  localparam int DEF_PWM_W         = 24;
  localparam int DEF_PWM_MAX       = 38000;
  localparam int DEF_PWM_INIT      = 19000;

  localparam int DEF_FINE_THR      = 10;
  localparam int DEF_COARSE_THR    = 50;
  localparam int DEF_FINE_STEP     = 1;
  localparam int DEF_COARSE_STEP   = 20;
  localparam int DEF_XCOARSE_STEP  = 200;

  localparam int DEF_LOCK_THR      = 2;
  localparam int DEF_LOCK_CNT      = 4;

endpackage

// File: rtl/vcxo_discipline_ctrl_sd_pwm.sv
// First-order sigma-delta modulator: turns the tuning code into a pulse
// density of code/PWM_MAX on the pump output feeding the loop filter.
module vcxo_sd_pwm
  import vcxo_discipline_ctrl_pkg::*;
#(
  parameter int PWM_W   = DEF_PWM_W,
  parameter int PWM_MAX = DEF_PWM_MAX
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic [PWM_W-1:0] code,
  output logic             pump
);

  localparam logic [PWM_W:0] L_MAX = (PWM_W+1)'(PWM_MAX);

  logic [PWM_W:0] r_acc;
  logic           r_pump;
  logic [PWM_W:0] w_sum;

  assign w_sum = r_acc + {1'b0, code};
  assign pump  = r_pump;

  // Accumulate the code each cycle and emit a pump pulse on every overflow past full scale.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_acc  <= '0;
      r_pump <= 1'b0;
    end else if (w_sum >= L_MAX) begin
      r_acc  <= w_sum - L_MAX;
      r_pump <= 1'b1;
    end else begin
      r_acc  <= w_sum;
      r_pump <= 1'b0;
    end
  end

endmodule

// File: rtl/vcxo_discipline_ctrl.sv
// VCXO disciplining controller. Counts clk_in cycles across a gate of
// GATE_EDGES reference edges, forms a frequency error, accepts it only when
// two consecutive gates agree, then nudges the tuning code and drives a
// sigma-delta pump. Optional lock detection is enabled by defining
// VCXO_LOCK_DETECT_EN.
module vcxo_discipline_ctrl
  import vcxo_discipline_ctrl_pkg::*;
#(
  parameter int NOMINAL_COUNT = DEF_NOMINAL_COUNT,
  parameter int GATE_EDGES    = DEF_GATE_EDGES,
  parameter int PWM_W         = DEF_PWM_W,
  parameter int PWM_MAX       = DEF_PWM_MAX,
  parameter int PWM_INIT      = DEF_PWM_INIT,
  parameter int FINE_THR      = DEF_FINE_THR,
  parameter int COARSE_THR    = DEF_COARSE_THR,
  parameter int FINE_STEP     = DEF_FINE_STEP,
  parameter int COARSE_STEP   = DEF_COARSE_STEP,
  parameter int XCOARSE_STEP  = DEF_XCOARSE_STEP,
  parameter int LOCK_THR      = DEF_LOCK_THR,
  parameter int LOCK_CNT      = DEF_LOCK_CNT
) (
  input  logic               clk_in,
  input  logic               reset_in,
  input  logic               ref_clk_in,
  input  logic signed [7:0]  correction_in,
  input  logic               hold_in,
  output logic signed [31:0] freq_error,
  output logic               error_valid,
  output logic [PWM_W-1:0]   pwm_value,
  output logic               pump,
  output logic               locked
);

  localparam logic [31:0]          L_NOMINAL   = 32'(NOMINAL_COUNT);
  localparam logic [31:0]          L_EDGE_LAST = 32'(GATE_EDGES - 1);
  localparam logic signed [31:0]   L_FINE_THR  = 32'(FINE_THR);
  localparam logic signed [31:0]   L_COARSE_THR = 32'(COARSE_THR);
  localparam logic signed [PWM_W:0] L_FINE_STEP  = (PWM_W+1)'(FINE_STEP);
  localparam logic signed [PWM_W:0] L_COARSE_STEP = (PWM_W+1)'(COARSE_STEP);
  localparam logic signed [PWM_W:0] L_XCOARSE_STEP = (PWM_W+1)'(XCOARSE_STEP);
  localparam logic signed [PWM_W:0] L_PWM_MIN  = (PWM_W+1)'(1);
  localparam logic signed [PWM_W:0] L_PWM_MAX  = (PWM_W+1)'(PWM_MAX);

  // Reference synchronizer and edge detector
  logic [1:0] r_refSync;
  logic       r_refPrev;
  logic       w_edge;

  // Measurement FSM
  measState_e  r_state;
  logic [31:0] r_cycleCnt;
  logic [31:0] r_edgeCnt;
  logic [31:0] r_capCount;
  logic        r_capValid;
  logic [31:0] w_cntNext;

  // Error and acceptance pipeline
  logic signed [31:0] r_err;
  logic               r_errStageValid;
  logic signed [31:0] r_prevErr;
  logic signed [31:0] r_freqError;
  logic               r_errorValid;
  logic [PWM_W-1:0]   r_pwm;
  logic               w_accept;
  logic [31:0]        w_corrExt;

  // Tuning step computation
  logic signed [PWM_W:0] w_step;
  logic signed [PWM_W:0] w_pwmSum;
  logic [PWM_W-1:0]      w_pwmNext;

  assign w_edge    = r_refSync[1] & ~r_refPrev;
  assign w_cntNext = (&r_cycleCnt) ? r_cycleCnt : r_cycleCnt + 32'd1;
  assign w_corrExt = {{24{correction_in[7]}}, correction_in};
  assign w_accept  = r_errStageValid && (r_err == r_prevErr);

  // Bring the asynchronous reference into the clk_in domain and keep the previous level for edge detection.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_refSync <= 2'b00;
      r_refPrev <= 1'b0;
    end else begin
      r_refSync <= {r_refSync[0], ref_clk_in};
      r_refPrev <= r_refSync[1];
    end
  end

  // Gate measurement: the stop edge of one gate is the start edge of the next, so no reference edge is lost.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_state    <= WAIT_START;
      r_cycleCnt <= '0;
      r_edgeCnt  <= '0;
      r_capCount <= '0;
      r_capValid <= 1'b0;
    end else begin
      r_capValid <= 1'b0;
      case (r_state)
        WAIT_START: begin
          if (w_edge) begin
            r_state    <= MEASURE;
            r_cycleCnt <= '0;
            r_edgeCnt  <= '0;
          end
        end
        MEASURE: begin
          if (w_edge && (r_edgeCnt == L_EDGE_LAST)) begin
            r_capCount <= w_cntNext;
            r_capValid <= 1'b1;
            r_cycleCnt <= '0;
            r_edgeCnt  <= '0;
          end else begin
            r_cycleCnt <= w_cntNext;
            if (w_edge) begin
              r_edgeCnt <= r_edgeCnt + 32'd1;
            end
          end
        end
        default: r_state <= WAIT_START;
      endcase
    end
  end

  // Convert a captured count into a trimmed, signed frequency error.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_err           <= '0;
      r_errStageValid <= 1'b0;
    end else begin
      r_errStageValid <= r_capValid;
      if (r_capValid) begin
        r_err <= r_capCount - L_NOMINAL + w_corrExt;
      end
    end
  end

  // Pick a tuning step from the error magnitude; positive error means the VCXO runs fast, so the code drops.
  always_comb begin
    w_step = '0;
    if (r_err < -L_COARSE_THR) begin
      w_step = L_XCOARSE_STEP;
    end else if (r_err < -L_FINE_THR) begin
      w_step = L_COARSE_STEP;
    end else if (r_err < 0) begin
      w_step = L_FINE_STEP;
    end else if (r_err > L_COARSE_THR) begin
      w_step = -L_XCOARSE_STEP;
    end else if (r_err > L_FINE_THR) begin
      w_step = -L_COARSE_STEP;
    end else if (r_err > 0) begin
      w_step = -L_FINE_STEP;
    end
  end

  // Apply the step with one extra sign bit of headroom and clamp into the legal code range.
  always_comb begin
    w_pwmSum  = $signed({1'b0, r_pwm}) + w_step;
    w_pwmNext = r_pwm;
    if (w_pwmSum < L_PWM_MIN) begin
      w_pwmNext = PWM_W'(1);
    end else if (w_pwmSum > L_PWM_MAX) begin
      w_pwmNext = PWM_W'(PWM_MAX);
    end else begin
      w_pwmNext = w_pwmSum[PWM_W-1:0];
    end
  end

  // Accept an error only when it repeats across two gates, which rejects gates disturbed by a single glitch.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_prevErr    <= '0;
      r_freqError  <= '0;
      r_errorValid <= 1'b0;
      r_pwm        <= PWM_W'(PWM_INIT);
    end else begin
      r_errorValid <= 1'b0;
      if (w_accept) begin
        r_freqError  <= r_err;
        r_errorValid <= 1'b1;
        if (!hold_in) begin
          r_pwm <= w_pwmNext;
        end
      end else if (r_errStageValid) begin
        r_prevErr <= r_err;
      end
    end
  end

`ifdef VCXO_LOCK_DETECT_EN
  localparam int                 LCW        = $clog2(LOCK_CNT + 1);
  localparam logic signed [31:0] L_LOCK_THR = 32'(LOCK_THR);

  logic [LCW-1:0] r_lockCnt;
  logic           r_locked;
  logic           w_errSmall;

  assign w_errSmall = (r_err >= -L_LOCK_THR) && (r_err <= L_LOCK_THR);
  assign locked     = r_locked;

  // Count consecutive small accepted errors; any large accepted error drops lock immediately.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_lockCnt <= '0;
      r_locked  <= 1'b0;
    end else if (w_accept) begin
      if (w_errSmall) begin
        if (r_lockCnt >= LCW'(LOCK_CNT - 1)) begin
          r_locked <= 1'b1;
        end
        if (r_lockCnt != LCW'(LOCK_CNT)) begin
          r_lockCnt <= r_lockCnt + LCW'(1);
        end
      end else begin
        r_lockCnt <= '0;
        r_locked  <= 1'b0;
      end
    end
  end
`else
  assign locked = 1'b0;
`endif

  assign freq_error  = r_freqError;
  assign error_valid = r_errorValid;
  assign pwm_value   = r_pwm;

  vcxo_sd_pwm #(
    .PWM_W   (PWM_W),
    .PWM_MAX (PWM_MAX)
  ) u_sdPwm (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .code     (r_pwm),
    .pump     (pump)
  );

endmodule
